// File: rtl/restoring_divider_16b_if.sv
// Operand/result handshake bundle for the restoring divider.
// The master (producer of operands, consumer of results) drives the i* signals;
// the divider (slave) drives the o* signals.
interface restoring_divider_16b_if #(
  parameter int WIDTH = 16
);
  logic             iValid;
  logic             oReady;
  logic [WIDTH-1:0] iDividend;
  logic [WIDTH-1:0] iDivisor;
  logic             oValid;
  logic             iReady;
  logic [WIDTH-1:0] oQuotient;
  logic [WIDTH-1:0] oRemainder;
  logic             oDivByZero;

  modport master (
    output iValid, iDividend, iDivisor, iReady,
    input  oReady, oValid, oQuotient, oRemainder, oDivByZero
  );

  modport slave (
    input  iValid, iDividend, iDivisor, iReady,
    output oReady, oValid, oQuotient, oRemainder, oDivByZero
  );
endinterface

// File: rtl/restoring_divider_16b.sv
// Iterative unsigned restoring divider: one trial subtraction per clock,
// WIDTH iterations per quotient. The trial subtract is done as A + ~B + 1 so the
// carry-out directly means "no borrow", matching the adder datapath next door.
// A zero divisor skips the iterations and reports an all-ones quotient with the
// dividend as remainder, flagged by oDivByZero.
module restoring_divider_16b #(
  parameter int WIDTH = 16
) (
  input  logic                  iClk,
  input  logic                  iRstN,
  restoring_divider_16b_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_rem;     // partial remainder R
  logic [WIDTH-1:0] r_quo;     // shifts dividend out / quotient bits in
  logic [WIDTH-1:0] r_div;     // latched divisor D
  logic [CW-1:0]    r_count;   // iteration index 0..WIDTH-1
  logic             r_valid;
  logic [WIDTH-1:0] r_q_out;
  logic [WIDTH-1:0] r_r_out;
  logic             r_dbz;

  logic             w_accept;
  logic             w_last_iter;
  logic [WIDTH:0]   w_rs;      // shifted remainder, WIDTH+1 bits
  logic [WIDTH+1:0] w_sum;     // carry-out plus WIDTH+1 bit difference
  logic             w_cout;    // 1 = Rs >= D, keep the difference
  logic [WIDTH-1:0] w_rem_next;
  logic [WIDTH-1:0] w_quo_next;

  assign w_accept    = bus.iValid && (r_state == S_IDLE);
  assign w_last_iter = (r_count == CW'(WIDTH - 1));

  // Trial subtract: Rs + ~{0,D} + 1. The carry out of bit WIDTH is no-borrow.
  // When it is set the difference is below D < 2^WIDTH, and when it is clear Rs
  // itself is below D, so the kept remainder always fits in WIDTH bits.
  assign w_rs       = {r_rem, r_quo[WIDTH-1]};
  assign w_sum      = {1'b0, w_rs} + {1'b0, ~{1'b0, r_div}} + {{(WIDTH+1){1'b0}}, 1'b1};
  assign w_cout     = w_sum[WIDTH+1];
  assign w_rem_next = w_cout ? w_sum[WIDTH-1:0] : w_rs[WIDTH-1:0];
  assign w_quo_next = {r_quo[WIDTH-2:0], w_cout};

  // Control FSM, iteration datapath and result registers.
  // NOTE: every register here is a flop written with <= so all of them see the
  // pre-edge values of each other; blocking = would chain iterations within one edge.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      r_state <= S_IDLE;
      r_rem   <= '0;
      r_quo   <= '0;
      r_div   <= '0;
      r_count <= '0;
      r_valid <= 1'b0;
      r_q_out <= '0;
      r_r_out <= '0;
      r_dbz   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_quo   <= bus.iDividend;
            r_div   <= bus.iDivisor;
            r_rem   <= '0;
            r_count <= '0;
            r_state <= (bus.iDivisor == '0) ? S_DONE : S_CALC;
          end
        end
        S_CALC: begin
          r_rem   <= w_rem_next;
          r_quo   <= w_quo_next;
          r_count <= r_count + CW'(1);
          if (w_last_iter) begin
            r_state <= S_DONE;
            r_valid <= 1'b1;
            r_q_out <= w_quo_next;
            r_r_out <= w_rem_next;
            r_dbz   <= 1'b0;
          end
        end
        S_DONE: begin
          if (!r_valid) begin
            // Only a zero divisor arrives here without a result yet: publish it
            // one edge after accept. r_quo still holds the untouched dividend.
            r_valid <= 1'b1;
            r_q_out <= '1;
            r_r_out <= r_quo;
            r_dbz   <= 1'b1;
          end else if (bus.iReady) begin
            // Result consumed: outputs keep their last value, valid drops.
            r_valid <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.oReady     = (r_state == S_IDLE);
  assign bus.oValid     = r_valid;
  assign bus.oQuotient  = r_q_out;
  assign bus.oRemainder = r_r_out;
  assign bus.oDivByZero = r_dbz;

endmodule

// File: tb/tb_restoring_divider_16b.sv
// Bench for restoring_divider_16b: directed cases with hand-computed results,
// then randomized back-to-back traffic. A scoreboard of expected results is
// computed with plain / and % and compared against the outputs every cycle.
module tb_restoring_divider_16b;

  localparam int W = 16;

  logic iClk  = 1'b0;
  logic iRstN = 1'b0;

  always #5 iClk = ~iClk;

  restoring_divider_16b_if #(.WIDTH(W)) bus ();

  restoring_divider_16b #(.WIDTH(W)) dut (
    .iClk  (iClk),
    .iRstN (iRstN),
    .bus   (bus)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    int           acc_edge;
  } exp_t;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  exp_t sb[$];

  // Compare-process state.
  exp_t         cur;
  logic [W-1:0] last_q;
  logic [W-1:0] last_r;
  logic         last_dbz;
  logic         prev_valid;
  int           busy;
  bit           spacing_on;
  bit           prev_spaced;
  bit           prev_acc_dbz;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e.a        = a;
    e.b        = b;
    e.acc_edge = 0;
    if (b == '0) begin
      e.q   = '1;
      e.r   = a;
      e.dbz = 1'b1;
    end else begin
      e.q   = a / b;
      e.r   = a % b;
      e.dbz = 1'b0;
    end
    return e;
  endfunction

  // Edge counter: after the n-th rising edge cyc == n.
  always @(posedge iClk) cyc <= cyc + 1;

  // Single compare process, sampling on the falling edge.
  always @(negedge iClk) begin
    if (!iRstN) begin
      sb.delete();
      last_q      = '0;
      last_r      = '0;
      last_dbz    = 1'b0;
      prev_valid  = 1'b0;
      busy        = 0;
      prev_spaced = 1'b0;
      check("rst_valid", 32'(bus.oValid), 32'd0);
      check("rst_q", 32'(bus.oQuotient), 32'd0);
      check("rst_r", 32'(bus.oRemainder), 32'd0);
      check("rst_dbz", 32'(bus.oDivByZero), 32'd0);
    end else begin
      if (bus.oValid) begin
        if (sb.size() == 0) begin
          check("unexpected_result", 32'd1, 32'd0);
        end else begin
          cur = sb[0];
          check("q", 32'(bus.oQuotient), 32'(cur.q));
          check("r", 32'(bus.oRemainder), 32'(cur.r));
          check("dbz", 32'(bus.oDivByZero), 32'(cur.dbz));
          if (!cur.dbz) begin
            check("invariant",
                  32'((32'(bus.oQuotient) * 32'(cur.b) + 32'(bus.oRemainder) == 32'(cur.a)) &&
                      (bus.oRemainder < cur.b)), 32'd1);
          end
          if (!prev_valid) check("latency", 32'(cyc - cur.acc_edge), cur.dbz ? 32'd1 : 32'(W));
          if (bus.iReady) begin
            void'(sb.pop_front());
            last_q   = bus.oQuotient;
            last_r   = bus.oRemainder;
            last_dbz = bus.oDivByZero;
          end
        end
      end else begin
        // Between results the outputs keep the last consumed value.
        check("hold_q", 32'(bus.oQuotient), 32'(last_q));
        check("hold_r", 32'(bus.oRemainder), 32'(last_r));
        check("hold_dbz", 32'(bus.oDivByZero), 32'(last_dbz));
      end

      if (!bus.oReady) busy++;
      if (bus.iValid && bus.oReady) begin
        if (spacing_on && prev_spaced) check("busy_cycles", 32'(busy), prev_acc_dbz ? 32'd2 : 32'(W + 1));
        cur          = model(bus.iDividend, bus.iDivisor);
        cur.acc_edge = cyc + 1;
        sb.push_back(cur);
        prev_acc_dbz = cur.dbz;
        prev_spaced  = spacing_on;
        busy         = 0;
      end
      prev_valid = bus.oValid;
    end
  end

  // Present operands until accepted; returns the index of the accept edge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, output int acc);
    int guard;
    guard         = 0;
    bus.iDividend = a;
    bus.iDivisor  = b;
    bus.iValid    = 1'b1;
    forever begin
      @(negedge iClk);
      if (bus.oReady) break;
      guard++;
      if (guard > 100) begin
        check("accept_timeout", 32'd0, 32'd1);
        break;
      end
    end
    acc = cyc + 1;
    @(posedge iClk);
    #1;
  endtask

  // Wait (bounded) for oValid; returns edges since accept.
  task automatic wait_result(input int acc, output int lat);
    int guard;
    guard = 0;
    lat   = -1;
    forever begin
      @(negedge iClk);
      if (bus.oValid) begin
        lat = cyc - acc;
        break;
      end
      guard++;
      if (guard > 100) begin
        check("result_timeout", 32'd0, 32'd1);
        break;
      end
    end
  endtask

  task automatic directed(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] eq, input logic [W-1:0] er,
                          input logic edbz, input int elat);
    int acc;
    int lat;
    issue(a, b, acc);
    bus.iValid = 1'b0;
    wait_result(acc, lat);
    check({name, "_lat"}, 32'(lat), 32'(elat));
    check({name, "_q"}, 32'(bus.oQuotient), 32'(eq));
    check({name, "_r"}, 32'(bus.oRemainder), 32'(er));
    check({name, "_dbz"}, 32'(bus.oDivByZero), 32'(edbz));
    @(posedge iClk);
    #1;
  endtask

  initial begin
    int acc;
    int lat;
    int guard;
    logic [W-1:0] a;
    logic [W-1:0] b;

    spacing_on    = 1'b0;
    bus.iValid    = 1'b0;
    bus.iReady    = 1'b1;
    bus.iDividend = '0;
    bus.iDivisor  = '0;

    repeat (3) @(negedge iClk);
    @(posedge iClk);
    #1 iRstN = 1'b1;
    @(negedge iClk);
    check("ready_after_reset", 32'(bus.oReady), 32'd1);

    // Main function and boundaries, hand-computed.
    directed("d100_7", 16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 16);
    directed("dffff_1", 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 16);
    directed("d5_9", 16'h0005, 16'h0009, 16'h0000, 16'h0005, 1'b0, 16);
    directed("d0_3", 16'h0000, 16'h0003, 16'h0000, 16'h0000, 1'b0, 16);
    directed("d1234_0", 16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1'b1, 1);
    directed("d1000_1000", 16'd1000, 16'd1000, 16'd1, 16'd0, 1'b0, 16);

    // Backpressure: result held, new operands ignored while busy.
    bus.iReady = 1'b0;
    issue(16'd40, 16'd6, acc);
    bus.iValid = 1'b0;
    wait_result(acc, lat);
    for (int i = 0; i < 5; i++) begin
      if (i == 0) begin
        @(posedge iClk);
        #1;
        bus.iDividend = 16'd9;
        bus.iDivisor  = 16'd3;
        bus.iValid    = 1'b1;
      end else if (i == 2) begin
        @(posedge iClk);
        #1 bus.iValid = 1'b0;
      end else begin
        @(posedge iClk);
      end
      @(negedge iClk);
      check("bp_ready_low", 32'(bus.oReady), 32'd0);
      check("bp_valid_high", 32'(bus.oValid), 32'd1);
      check("bp_q", 32'(bus.oQuotient), 32'd6);
      check("bp_r", 32'(bus.oRemainder), 32'd4);
    end
    @(posedge iClk);
    #1 bus.iReady = 1'b1;
    @(negedge iClk);
    @(negedge iClk);
    check("bp_ready_after", 32'(bus.oReady), 32'd1);
    check("bp_valid_after", 32'(bus.oValid), 32'd0);
    check("bp_nothing_queued", 32'(sb.size()), 32'd0);

    // Reset in the middle of an iteration run.
    issue(16'hABCD, 16'h0013, acc);
    bus.iValid = 1'b0;
    repeat (7) @(posedge iClk);
    #1 iRstN = 1'b0;
    #1;
    check("abort_valid", 32'(bus.oValid), 32'd0);
    check("abort_q", 32'(bus.oQuotient), 32'd0);
    check("abort_r", 32'(bus.oRemainder), 32'd0);
    check("abort_dbz", 32'(bus.oDivByZero), 32'd0);
    @(negedge iClk);
    @(posedge iClk);
    #1 iRstN = 1'b1;
    @(negedge iClk);
    check("abort_ready_after", 32'(bus.oReady), 32'd1);
    // 0xABCD = 43981 = 19 * 2314 + 15
    directed("dabcd_13", 16'hABCD, 16'h0013, 16'h090A, 16'h000F, 1'b0, 16);

    // Randomized back-to-back traffic with iReady held high.
    spacing_on = 1'b1;
    for (int n = 0; n < 2000; n++) begin
      case ($urandom_range(0, 7))
        0:       b = '0;
        1, 2:    b = W'($urandom_range(1, 15));
        3:       b = W'($urandom_range(256, 65535));
        default: b = W'($urandom);
      endcase
      case ($urandom_range(0, 5))
        0:       a = W'($urandom_range(0, 31));
        1:       a = 16'hFFFF;
        default: a = W'($urandom);
      endcase
      issue(a, b, acc);
    end
    bus.iValid = 1'b0;
    guard = 0;
    while (sb.size() != 0 && guard < 100) begin
      @(negedge iClk);
      guard++;
    end
    check("drain", 32'(sb.size()), 32'd0);
    spacing_on = 1'b0;
    repeat (2) @(negedge iClk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
